// File: rtl/cla_sweep_checker_if.sv
// Bus between the sweep checker, its controller and the 4-bit adder under test.
// The checker sits on the slave side: it takes start requests and adder results,
// and it drives operands, status and results.
interface cla_sweep_checker_if;
  logic       start;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_cin;
  logic [3:0] dut_s;
  logic       dut_cout;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_count;
  logic [8:0] first_err_vec;
  logic       first_err_valid;

  modport slave (
    input  start, dut_s, dut_cout,
    output dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );

  modport master (
    output start, dut_s, dut_cout,
    input  dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/cla_sweep_checker.sv
// Exhaustive checker for a 4-bit adder with carry-in: walks all 512
// {a, b, cin} combinations, waits SETTLE cycles per vector, compares the
// returned {cout, s} with the true sum and reports error count and the
// index of the first failing vector.
module cla_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_sweep_checker_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t     state, state_nx;
  logic [8:0] idx;
  logic [3:0] wcnt;
  logic [3:0] a_q, b_q;
  logic       cin_q;
  logic [9:0] err_q;
  logic [8:0] fev_q;
  logic       fevld_q;
  logic [4:0] ref_sum;
  logic       mismatch;
  logic       busy_c, done_c;

  // Reference sum of the operands currently on the adder inputs, and the compare.
  always_comb begin
    ref_sum  = {1'b0, a_q} + {1'b0, b_q} + {4'b0, cin_q};
    mismatch = ({bus.dut_cout, bus.dut_s} != ref_sum);
  end

  // Next-state and status decode.
  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = DRIVE;
      end
      DRIVE: begin
        busy_c   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        busy_c = 1'b1;
        if (wcnt <= 4'd1) state_nx = CHECK;
      end
      CHECK: begin
        busy_c   = 1'b1;
        state_nx = (idx == 9'd511) ? DONE : DRIVE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) state_nx = DRIVE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Vector index, settle counter, operand registers and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      wcnt    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      err_q   <= '0;
      fev_q   <= '0;
      fevld_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            idx     <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevld_q <= 1'b0;
          end
        end
        DRIVE: begin
          {a_q, b_q, cin_q} <= idx;
          wcnt              <= 4'(SETTLE);
        end
        WAIT: begin
          wcnt <= wcnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err_q <= err_q + 10'd1;
            if (!fevld_q) begin
              fev_q   <= idx;
              fevld_q <= 1'b1;
            end
          end
          if (idx != 9'd511) idx <= idx + 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_a           = a_q;
  assign bus.dut_b           = b_q;
  assign bus.dut_cin         = cin_q;
  assign bus.busy            = busy_c;
  assign bus.done            = done_c;
  assign bus.pass            = done_c && (err_q == '0);
  assign bus.err_count       = err_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fevld_q;

endmodule

// File: tb/tb_cla_sweep_checker.sv
// Directed bench for cla_sweep_checker: a behavioural 4-bit adder with
// selectable faults feeds a SETTLE=1 instance; an ideal adder feeds a
// SETTLE=3 instance.
module tb_cla_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   fault;   // 0 ideal, 1 cout stuck at 0, 2 s[0] inverted
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cla_sweep_checker_if bus1();
  cla_sweep_checker_if bus3();

  logic [4:0] sum1, sum3;
  assign sum1          = {1'b0, bus1.dut_a} + {1'b0, bus1.dut_b} + {4'b0, bus1.dut_cin};
  assign bus1.dut_s    = (fault == 2) ? (sum1[3:0] ^ 4'd1) : sum1[3:0];
  assign bus1.dut_cout = (fault == 1) ? 1'b0 : sum1[4];
  assign sum3          = {1'b0, bus3.dut_a} + {1'b0, bus3.dut_b} + {4'b0, bus3.dut_cin};
  assign bus3.dut_s    = sum3[3:0];
  assign bus3.dut_cout = sum3[4];

  cla_sweep_checker #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cla_sweep_checker #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Called at #1 after an edge; start is sampled on the next edge.
  task automatic pulse_start1();
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done1(input int limit, output int cycles);
    cycles = 0;
    while (bus1.done !== 1'b1 && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.start = 1'b1;
    bus3.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus1.busy); end
    n_chk++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus1.done); end
    n_chk++; if (bus1.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b expected 0", bus1.pass); end
    n_chk++; if (bus1.err_count !== 10'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", bus1.err_count); end
    n_chk++; if ({bus1.first_err_valid, bus1.first_err_vec} !== 10'd0) begin n_fail++; $display("FAIL reset_first: got %0b/%0d expected 0/0", bus1.first_err_valid, bus1.first_err_vec); end
    n_chk++; if ({bus1.dut_a, bus1.dut_b, bus1.dut_cin} !== 9'd0) begin n_fail++; $display("FAIL reset_operands: got %0h/%0h/%0b expected 0/0/0", bus1.dut_a, bus1.dut_b, bus1.dut_cin); end
    rst_n = 1'b1;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_reset_ignored: busy got %0b expected 0", bus1.busy); end
    n_chk++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_reset_ignored3: busy got %0b expected 0", bus3.busy); end
  endtask

  task automatic test_ideal_sweep();
    int cyc;
    fault = 0;
    pulse_start1();
    n_chk++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL ideal_busy: got %0b expected 1", bus1.busy); end
    wait_done1(5000, cyc);
    n_chk++; if (cyc !== 1536) begin n_fail++; $display("FAIL ideal_latency: got %0d expected 1536", cyc); end
    n_chk++; if (bus1.pass !== 1'b1) begin n_fail++; $display("FAIL ideal_pass: got %0b expected 1", bus1.pass); end
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL ideal_busy_done: got %0b expected 0", bus1.busy); end
    n_chk++; if (bus1.err_count !== 10'd0) begin n_fail++; $display("FAIL ideal_err: got %0d expected 0", bus1.err_count); end
    n_chk++; if ({bus1.first_err_valid, bus1.first_err_vec} !== 10'd0) begin n_fail++; $display("FAIL ideal_first: got %0b/%0d expected 0/0", bus1.first_err_valid, bus1.first_err_vec); end
  endtask

  task automatic test_cout_stuck();
    int cyc;
    fault = 1;
    pulse_start1();
    wait_done1(5000, cyc);
    n_chk++; if (cyc !== 1536) begin n_fail++; $display("FAIL cout_latency: got %0d expected 1536", cyc); end
    n_chk++; if (bus1.err_count !== 10'd256) begin n_fail++; $display("FAIL cout_err: got %0d expected 256", bus1.err_count); end
    n_chk++; if (bus1.first_err_vec !== 9'h01F) begin n_fail++; $display("FAIL cout_first_vec: got %0h expected 1f", bus1.first_err_vec); end
    n_chk++; if (bus1.first_err_valid !== 1'b1) begin n_fail++; $display("FAIL cout_first_valid: got %0b expected 1", bus1.first_err_valid); end
    n_chk++; if (bus1.pass !== 1'b0) begin n_fail++; $display("FAIL cout_pass: got %0b expected 0", bus1.pass); end
  endtask

  task automatic test_sum_bit_flip();
    int cyc;
    fault = 2;
    pulse_start1();
    wait_done1(5000, cyc);
    n_chk++; if (bus1.err_count !== 10'd512) begin n_fail++; $display("FAIL flip_err: got %0d expected 512", bus1.err_count); end
    n_chk++; if (bus1.first_err_vec !== 9'd0) begin n_fail++; $display("FAIL flip_first_vec: got %0h expected 0", bus1.first_err_vec); end
    n_chk++; if (bus1.first_err_valid !== 1'b1) begin n_fail++; $display("FAIL flip_first_valid: got %0b expected 1", bus1.first_err_valid); end
    n_chk++; if (bus1.pass !== 1'b0) begin n_fail++; $display("FAIL flip_pass: got %0b expected 0", bus1.pass); end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    fault = 2;
    pulse_start1();
    repeat (100) @(posedge clk);
    #1;
    // 33 checks done (every 3rd edge), vector 33 now on the operands
    n_chk++; if (bus1.err_count !== 10'd33) begin n_fail++; $display("FAIL mid_err_before: got %0d expected 33", bus1.err_count); end
    n_chk++; if ({bus1.dut_a, bus1.dut_b, bus1.dut_cin} !== 9'd33) begin n_fail++; $display("FAIL mid_operands_before: got %0d expected 33", {bus1.dut_a, bus1.dut_b, bus1.dut_cin}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b expected 0", bus1.busy); end
    n_chk++; if (bus1.err_count !== 10'd0) begin n_fail++; $display("FAIL mid_err: got %0d expected 0", bus1.err_count); end
    n_chk++; if ({bus1.dut_a, bus1.dut_b, bus1.dut_cin} !== 9'd0) begin n_fail++; $display("FAIL mid_operands: got %0d expected 0", {bus1.dut_a, bus1.dut_b, bus1.dut_cin}); end
    n_chk++; if ({bus1.first_err_valid, bus1.first_err_vec} !== 10'd0) begin n_fail++; $display("FAIL mid_first: got %0b/%0d expected 0/0", bus1.first_err_valid, bus1.first_err_vec); end
    fault = 0;
    pulse_start1();
    wait_done1(5000, cyc);
    n_chk++; if (cyc !== 1536) begin n_fail++; $display("FAIL mid_rerun_latency: got %0d expected 1536", cyc); end
    n_chk++; if (bus1.pass !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_pass: got %0b expected 1", bus1.pass); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fault = 0;
    pulse_start1();
    cyc = 0;
    while (bus1.done !== 1'b1 && cyc < 5000) begin
      bus1.start = ((cyc % 7) == 3);
      @(posedge clk); #1;
      cyc++;
    end
    bus1.start = 1'b0;
    n_chk++; if (cyc !== 1536) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 1536", cyc); end
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (bus1.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_hold: got %0b expected 1", bus1.done); end
    n_chk++; if ({bus1.dut_a, bus1.dut_b, bus1.dut_cin} !== 9'd511) begin n_fail++; $display("FAIL b2b_operands_hold: got %0d expected 511", {bus1.dut_a, bus1.dut_b, bus1.dut_cin}); end
    pulse_start1();
    n_chk++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_done: got %0b expected 0", bus1.done); end
    n_chk++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %0b expected 1", bus1.busy); end
    wait_done1(5000, cyc);
    n_chk++; if (cyc !== 1536) begin n_fail++; $display("FAIL b2b_rerun_latency: got %0d expected 1536", cyc); end
    n_chk++; if (bus1.pass !== 1'b1) begin n_fail++; $display("FAIL b2b_rerun_pass: got %0b expected 1", bus1.pass); end
  endtask

  task automatic test_settle3();
    int cyc;
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    cyc = 0;
    while (bus3.done !== 1'b1 && cyc < 8000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (cyc !== 2560) begin n_fail++; $display("FAIL settle3_latency: got %0d expected 2560", cyc); end
    n_chk++; if (bus3.pass !== 1'b1) begin n_fail++; $display("FAIL settle3_pass: got %0b expected 1", bus3.pass); end
    n_chk++; if (bus3.err_count !== 10'd0) begin n_fail++; $display("FAIL settle3_err: got %0d expected 0", bus3.err_count); end
  endtask

  initial begin
    fault = 0;
    rst_n = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    test_reset();
    test_ideal_sweep();
    test_cout_stuck();
    test_sum_bit_flip();
    test_reset_mid_sweep();
    test_back_to_back();
    test_settle3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
